mem_access: RTL and testbench



---
 rtl/mem_access_pkg.sv | 28 ++
 rtl/mem_lane_unit.sv | 84 ++++++++
 rtl/mem_access.sv | 187 ++++++++++++++++++
 tb/tb_mem_access.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: load/store op encodings, FSM states
// and pipeline constants.
package mem_access_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [3:0] MEM_OP_NONE = 4'd0;
    localparam logic [3:0] MEM_OP_LB   = 4'd1;
    localparam logic [3:0] MEM_OP_LBU  = 4'd2;
    localparam logic [3:0] MEM_OP_LH   = 4'd3;
    localparam logic [3:0] MEM_OP_LHU  = 4'd4;
    localparam logic [3:0] MEM_OP_LW   = 4'd5;
    localparam logic [3:0] MEM_OP_SB   = 4'd6;
    localparam logic [3:0] MEM_OP_SH   = 4'd7;
    localparam logic [3:0] MEM_OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WORD_W-1:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]        NOPRegAddr   = 5'd0;
    localparam logic              WriteEnable  = 1'b1;
    localparam logic              WriteDisable = 1'b0;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane logic for loads/stores (purely combinational).
// Ports:
//   op, addr_lo          : memory op and low address bits
//   st_data, rdata       : store source value, bus read data
//   is_load_c/is_store_c : decoded access type (ops 9-15 decode as neither)
//   misaligned_c         : half/word access not naturally aligned
//   sel_c, wdata_c       : byte selects and replicated store data
//   ld_data_c            : selected lane(s) of rdata, sign/zero extended
module mem_lane_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned BIG_ENDIAN = 1
) (
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic        is_load_c,
    output logic        is_store_c,
    output logic        misaligned_c,
    output logic [3:0]  sel_c,
    output logic [31:0] wdata_c,
    output logic [31:0] ld_data_c
);

    // Physical lane index: lane i is rdata[8i+7:8i]. Big-endian puts addr 0 in lane 3.
    logic [1:0]  byte_lane;
    logic        half_hi;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_lane = (BIG_ENDIAN != 0) ? ~addr_lo : addr_lo;
    assign half_hi   = (BIG_ENDIAN != 0) ? ~addr_lo[1] : addr_lo[1];
    assign byte_v    = rdata[{byte_lane, 3'b000} +: 8];
    assign half_v    = half_hi ? rdata[31:16] : rdata[15:0];

    // Decode op into lane selects, store replication and load extension.
    always_comb begin
        is_load_c    = 1'b0;
        is_store_c   = 1'b0;
        misaligned_c = 1'b0;
        sel_c        = 4'b0000;
        wdata_c      = ZeroWord;
        ld_data_c    = ZeroWord;
        case (op)
            MEM_OP_LB, MEM_OP_LBU: begin
                is_load_c = 1'b1;
                sel_c     = 4'(4'b0001 << byte_lane);
                ld_data_c = (op == MEM_OP_LB) ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
            end
            MEM_OP_LH, MEM_OP_LHU: begin
                is_load_c    = 1'b1;
                misaligned_c = addr_lo[0];
                sel_c        = half_hi ? 4'b1100 : 4'b0011;
                ld_data_c    = (op == MEM_OP_LH) ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
            end
            MEM_OP_LW: begin
                is_load_c    = 1'b1;
                misaligned_c = (addr_lo != 2'b00);
                sel_c        = 4'b1111;
                ld_data_c    = rdata;
            end
            MEM_OP_SB: begin
                is_store_c = 1'b1;
                sel_c      = 4'(4'b0001 << byte_lane);
                wdata_c    = {4{st_data[7:0]}};
            end
            MEM_OP_SH: begin
                is_store_c   = 1'b1;
                misaligned_c = addr_lo[0];
                sel_c        = half_hi ? 4'b1100 : 4'b0011;
                wdata_c      = {2{st_data[15:0]}};
            end
            MEM_OP_SW: begin
                is_store_c   = 1'b1;
                misaligned_c = (addr_lo != 2'b00);
                sel_c        = 4'b1111;
                wdata_c      = st_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU/HI-LO results through and runs loads/stores
// over a req/ack data bus with wait states, stall request, alignment check
// and bus timeout.
// Ports:
//   clk, rst (sync, active-high)
//   mem_op_i, mem_addr_i, st_data_i        : access from EX/MEM
//   wd_i/wreg_i/wdata_i, hi_i/lo_i/whilo_i : writeback results from EX/MEM
//   wd_o/wreg_o/wdata_o, hi_o/lo_o/whilo_o : to MEM/WB
//   stall_req_o, align_exc_o, bus_err_o    : pipeline control / exceptions
//   mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o : data bus request
//   mem_ack_i, mem_err_i, mem_rdata_i      : data bus response
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned BIG_ENDIAN  = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           st_data_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [31:0]           hi_i,
    input  logic [31:0]           lo_i,
    input  logic                  whilo_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic [31:0]           hi_o,
    output logic [31:0]           lo_o,
    output logic                  whilo_o,
    output logic                  stall_req_o,
    output logic                  align_exc_o,
    output logic                  bus_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [3:0]            mem_sel_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic                  mem_err_i,
    input  logic [31:0]           mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t         state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]    load_q;
    logic           err_q;

    logic           is_load;
    logic           is_store;
    logic           misaligned;
    logic [3:0]     sel;
    logic [31:0]    st_wdata;
    logic [31:0]    ld_data;

    mem_lane_unit #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .op           (mem_op_i),
        .addr_lo      (mem_addr_i[1:0]),
        .st_data      (st_data_i),
        .rdata        (mem_rdata_i),
        .is_load_c    (is_load),
        .is_store_c   (is_store),
        .misaligned_c (misaligned),
        .sel_c        (sel),
        .wdata_c      (st_wdata),
        .ld_data_c    (ld_data)
    );

    // State, wait counter and captured load data. The counter is 1 in the
    // first WAIT cycle, so a timeout fires in the TIMEOUT_CYC-th WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            load_q   <= ZeroWord;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((is_load || is_store) && !misaligned) begin
                        state    <= ST_WAIT;
                        wait_cnt <= CNT_W'(1);
                        err_q    <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // Error beats ack; ack beats timeout.
                    if (mem_err_i) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else if (mem_ack_i) begin
                        load_q <= ld_data;
                        state  <= ST_DONE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYC)) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage outputs. Reset forces every output low so a request in flight
    // is dropped at once. Writeback and HI/LO commit are suppressed while
    // stalled so they happen exactly once, in DONE.
    always_comb begin
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        hi_o        = hi_i;
        lo_o        = lo_i;
        whilo_o     = whilo_i;
        stall_req_o = 1'b0;
        align_exc_o = 1'b0;
        bus_err_o   = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_sel_o   = 4'b0000;
        mem_wdata_o = ZeroWord;
        if (rst) begin
            wd_o    = REG_ADDR_W'(NOPRegAddr);
            wreg_o  = WriteDisable;
            wdata_o = ZeroWord;
            hi_o    = ZeroWord;
            lo_o    = ZeroWord;
            whilo_o = WriteDisable;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (misaligned) begin
                        align_exc_o = 1'b1;
                        wreg_o      = WriteDisable;
                    end else if (is_load || is_store) begin
                        stall_req_o = 1'b1;
                        wreg_o      = WriteDisable;
                        whilo_o     = WriteDisable;
                        mem_req_o   = 1'b1;
                        mem_we_o    = is_store;
                        mem_addr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};
                        mem_sel_o   = sel;
                        mem_wdata_o = st_wdata;
                    end
                end
                ST_WAIT: begin
                    // Inputs are held while stalled, so the request stays stable.
                    stall_req_o = 1'b1;
                    wreg_o      = WriteDisable;
                    whilo_o     = WriteDisable;
                    mem_req_o   = 1'b1;
                    mem_we_o    = is_store;
                    mem_addr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};
                    mem_sel_o   = sel;
                    mem_wdata_o = st_wdata;
                end
                ST_DONE: begin
                    if (is_load) begin
                        wdata_o = load_q;
                    end
                    if (err_q) begin
                        wreg_o    = WriteDisable;
                        bus_err_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: table of single-access vectors plus
// hand-written sequences for wait states, timeout, error and reset-in-WAIT.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] st_data_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        whilo_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        whilo_o;
    logic        stall_req_o;
    logic        align_exc_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic        mem_err_i;
    logic [31:0] mem_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access #(
        .ADDR_W      (32),
        .REG_ADDR_W  (5),
        .BIG_ENDIAN  (1),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .st_data_i   (st_data_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .whilo_i     (whilo_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .whilo_o     (whilo_o),
        .stall_req_o (stall_req_o),
        .align_exc_o (align_exc_o),
        .bus_err_o   (bus_err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_sel_o   (mem_sel_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_err_i   (mem_err_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] st;
        logic [31:0] rdata;
        logic        stall;     // aligned access: request + stall
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  sel;
        logic [31:0] mwdata;
        logic        align;
        logic [31:0] done_wdata; // wdata_o in DONE (or pass-through value)
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [3:0] op, logic [31:0] addr,
                                logic [31:0] st, logic [31:0] rdata, logic stall,
                                logic we, logic [31:0] maddr, logic [3:0] sel,
                                logic [31:0] mwdata, logic align, logic [31:0] done_wdata);
        vec_t v;
        v.name = name; v.op = op; v.addr = addr; v.st = st; v.rdata = rdata;
        v.stall = stall; v.we = we; v.maddr = maddr; v.sel = sel;
        v.mwdata = mwdata; v.align = align; v.done_wdata = done_wdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe_defaults();
        wd_i    = 5'd5;
        wreg_i  = 1'b1;
        wdata_i = 32'h0000_1234;
        hi_i    = 32'h1111_2222;
        lo_i    = 32'h3333_4444;
        whilo_i = 1'b1;
    endtask

    initial begin
        // Table: BIG_ENDIAN=1, wdata_i=0x1234 for every vector.
        vecs.push_back(mk("none",     4'd0,  32'h0000_0000, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0000_1234));
        vecs.push_back(mk("op12",     4'd12, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0000_1234));
        vecs.push_back(mk("lb_1003",  4'd1,  32'h0000_1003, 32'h0, 32'h0000_00F0, 1, 0, 32'h0000_1000, 4'b0001, 32'h0, 0, 32'hFFFF_FFF0));
        vecs.push_back(mk("lbu_1003", 4'd2,  32'h0000_1003, 32'h0, 32'h0000_00F0, 1, 0, 32'h0000_1000, 4'b0001, 32'h0, 0, 32'h0000_00F0));
        vecs.push_back(mk("lb_1000",  4'd1,  32'h0000_1000, 32'h0, 32'h7F00_0000, 1, 0, 32'h0000_1000, 4'b1000, 32'h0, 0, 32'h0000_007F));
        vecs.push_back(mk("lh_2000",  4'd3,  32'h0000_2000, 32'h0, 32'h8001_1234, 1, 0, 32'h0000_2000, 4'b1100, 32'h0, 0, 32'hFFFF_8001));
        vecs.push_back(mk("lhu_2002", 4'd4,  32'h0000_2002, 32'h0, 32'h8001_9234, 1, 0, 32'h0000_2000, 4'b0011, 32'h0, 0, 32'h0000_9234));
        vecs.push_back(mk("lw_3004",  4'd5,  32'h0000_3004, 32'h0, 32'hDEAD_BEEF, 1, 0, 32'h0000_3004, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF));
        vecs.push_back(mk("sh_2002",  4'd7,  32'h0000_2002, 32'hABCD_1234, 32'h0, 1, 1, 32'h0000_2000, 4'b0011, 32'h1234_1234, 0, 32'h0000_1234));
        vecs.push_back(mk("sb_4001",  4'd6,  32'h0000_4001, 32'h0000_00A5, 32'h0, 1, 1, 32'h0000_4000, 4'b0100, 32'hA5A5_A5A5, 0, 32'h0000_1234));
        vecs.push_back(mk("sw_4008",  4'd8,  32'h0000_4008, 32'hCAFE_F00D, 32'h0, 1, 1, 32'h0000_4008, 4'b1111, 32'hCAFE_F00D, 0, 32'h0000_1234));
        vecs.push_back(mk("lw_mis",   4'd5,  32'h0000_3001, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h0000_1234));
        vecs.push_back(mk("lh_mis",   4'd3,  32'h0000_2001, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h0000_1234));
        vecs.push_back(mk("sw_mis",   4'd8,  32'h0000_4002, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h0000_1234));
        vecs.push_back(mk("sh_mis",   4'd7,  32'h0000_2003, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h0000_1234));

        // Reset: inputs busy, every output must read 0.
        rst = 1'b1;
        set_pipe_defaults();
        mem_op_i = 4'd5; mem_addr_i = 32'h0; st_data_i = 32'hFFFF_FFFF;
        mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = 32'h0;
        tick();
        tick();
        chk("rst_wd",    32'(wd_o), 32'h0);
        chk("rst_wreg",  32'(wreg_o), 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_whilo", 32'(whilo_o), 32'h0);
        chk("rst_hi",    hi_o, 32'h0);
        chk("rst_req",   32'(mem_req_o), 32'h0);
        chk("rst_stall", 32'(stall_req_o), 32'h0);
        rst = 1'b0;
        mem_op_i = 4'd0;

        // Table-driven single accesses; aligned ones ack in the first WAIT cycle.
        foreach (vecs[i]) begin
            tick();
            mem_op_i    = vecs[i].op;
            mem_addr_i  = vecs[i].addr;
            st_data_i   = vecs[i].st;
            mem_rdata_i = 32'h0;
            mem_ack_i   = 1'b0;
            #1;
            chk({vecs[i].name, "_stall"}, 32'(stall_req_o), 32'(vecs[i].stall));
            chk({vecs[i].name, "_req"},   32'(mem_req_o),   32'(vecs[i].stall));
            chk({vecs[i].name, "_align"}, 32'(align_exc_o), 32'(vecs[i].align));
            chk({vecs[i].name, "_wd"},    32'(wd_o), 32'd5);
            chk({vecs[i].name, "_hi"},    hi_o, 32'h1111_2222);
            chk({vecs[i].name, "_lo"},    lo_o, 32'h3333_4444);
            if (vecs[i].stall) begin
                chk({vecs[i].name, "_we"},     32'(mem_we_o), 32'(vecs[i].we));
                chk({vecs[i].name, "_maddr"},  mem_addr_o, vecs[i].maddr);
                chk({vecs[i].name, "_sel"},    32'(mem_sel_o), 32'(vecs[i].sel));
                chk({vecs[i].name, "_whilo0"}, 32'(whilo_o), 32'h0);
                if (vecs[i].we) chk({vecs[i].name, "_mwdata"}, mem_wdata_o, vecs[i].mwdata);
                tick();
                mem_ack_i   = 1'b1;
                mem_rdata_i = vecs[i].rdata;
                #1;
                chk({vecs[i].name, "_wait_stall"}, 32'(stall_req_o), 32'h1);
                chk({vecs[i].name, "_wait_sel"},   32'(mem_sel_o), 32'(vecs[i].sel));
                tick();
                mem_ack_i   = 1'b0;
                mem_rdata_i = 32'h0;
                #1;
                chk({vecs[i].name, "_done_wdata"}, wdata_o, vecs[i].done_wdata);
                chk({vecs[i].name, "_done_wreg"},  32'(wreg_o), 32'h1);
                chk({vecs[i].name, "_done_whilo"}, 32'(whilo_o), 32'h1);
                chk({vecs[i].name, "_done_stall"}, 32'(stall_req_o), 32'h0);
                chk({vecs[i].name, "_done_req"},   32'(mem_req_o), 32'h0);
                chk({vecs[i].name, "_done_err"},   32'(bus_err_o), 32'h0);
            end else begin
                chk({vecs[i].name, "_wdata"}, wdata_o, vecs[i].done_wdata);
                chk({vecs[i].name, "_wreg"},  32'(wreg_o), vecs[i].align ? 32'h0 : 32'h1);
                chk({vecs[i].name, "_whilo"}, 32'(whilo_o), 32'h1);
            end
        end

        // LB with ack after two WAIT cycles: stall high for exactly 3 cycles.
        begin
            int stall_cycles;
            stall_cycles = 0;
            tick();
            mem_op_i = 4'd1; mem_addr_i = 32'h0000_1003; mem_ack_i = 1'b0;
            #1;
            if (stall_req_o) stall_cycles++;
            tick(); #1;
            if (stall_req_o) stall_cycles++;
            chk("lb2_w1_req", 32'(mem_req_o), 32'h1);
            tick();
            mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_00F0;
            #1;
            if (stall_req_o) stall_cycles++;
            tick();
            mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
            #1;
            if (stall_req_o) stall_cycles++;
            chk("lb2_stall_cycles", 32'(stall_cycles), 32'd3);
            chk("lb2_done_wdata", wdata_o, 32'hFFFF_FFF0);
        end

        // LW with no ack: request held for 4 WAIT cycles, then timeout error.
        tick();
        mem_op_i = 4'd5; mem_addr_i = 32'h0000_0000;
        for (int c = 1; c <= 4; c++) begin
            tick(); #1;
            chk($sformatf("to_wait%0d_req", c), 32'(mem_req_o), 32'h1);
        end
        tick(); #1;
        chk("to_done_err",  32'(bus_err_o), 32'h1);
        chk("to_done_wreg", 32'(wreg_o), 32'h0);
        chk("to_done_req",  32'(mem_req_o), 32'h0);
        chk("to_done_stall", 32'(stall_req_o), 32'h0);
        mem_op_i = 4'd0;
        tick(); #1;
        chk("to_idle_err", 32'(bus_err_o), 32'h0);

        // Error and ack together: error wins.
        mem_op_i = 4'd5; mem_addr_i = 32'h0000_0010;
        tick();
        mem_ack_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'h5555_5555;
        tick();
        mem_ack_i = 1'b0; mem_err_i = 1'b0;
        #1;
        chk("errack_err",  32'(bus_err_o), 32'h1);
        chk("errack_wreg", 32'(wreg_o), 32'h0);

        // Reset while in WAIT drops the request; a following LW completes.
        tick();
        mem_op_i = 4'd5; mem_addr_i = 32'h0000_0020;
        tick(); #1;
        chk("rw_wait_req", 32'(mem_req_o), 32'h1);
        rst = 1'b1;
        #1;
        chk("rw_rst_req", 32'(mem_req_o), 32'h0);
        tick();
        rst = 1'b0; mem_op_i = 4'd0;
        #1;
        chk("rw_idle_req",   32'(mem_req_o), 32'h0);
        chk("rw_idle_stall", 32'(stall_req_o), 32'h0);
        mem_op_i = 4'd5; mem_addr_i = 32'h0000_0000;
        #1;
        chk("rw_lw_req",   32'(mem_req_o), 32'h1);
        chk("rw_lw_maddr", mem_addr_o, 32'h0);
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1122_3344;
        tick();
        mem_ack_i = 1'b0;
        #1;
        chk("rw_lw_wdata", wdata_o, 32'h1122_3344);
        chk("rw_lw_wreg",  32'(wreg_o), 32'h1);
        chk("rw_lw_err",   32'(bus_err_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
